dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// +-----------------------------------------------------------------------+
// | dmem_responder_if : MEM-stage request/response bus  (rev 1.0)          |
// +-----------------------------------------------------------------------+
`default_nettype none

interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        stall;

  modport master (output req, we, size, addr, wdata, input rdata, ready, err, stall);
  modport slave  (input req, we, size, addr, wdata, output rdata, ready, err, stall);
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// +-----------------------------------------------------------------------+
// | dmem_responder : byte-lane data memory with wait states  (rev 1.0)     |
// +-----------------------------------------------------------------------+
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         lane_q, lane_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem [2**ADDR_W];

  logic               illegal;
  logic [31:0]        word;
  logic [31:0]        word_sh;
  logic [31:0]        rd_lane;
  logic [31:0]        wr_rep;
  logic [31:0]        merged;
  logic [3:0]         be;
  logic               ready_w;

  always_comb begin
    illegal = 1'b0;
    case (bus.size)
      2'b01:   illegal = bus.addr[0];
      2'b10:   illegal = (bus.addr[1:0] != 2'b00);
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
    if (bus.addr[31:ADDR_W+2] != '0) illegal = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = bus.size;
          lane_d  = bus.addr[1:0];
          idx_d   = bus.addr[ADDR_W+1:2];
          wdata_d = bus.wdata;
          err_d   = illegal;
          if (illegal || (WAIT_CYCLES == 0)) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Lane replication lets one byte-enable mask serve every access size.
  always_comb begin
    word    = mem[idx_q];
    word_sh = word >> {lane_q, 3'b000};
    be      = 4'b1111;
    wr_rep  = wdata_q;
    rd_lane = word;
    case (size_q)
      2'b00: begin
        be      = 4'b0001 << lane_q;
        wr_rep  = {4{wdata_q[7:0]}};
        rd_lane = {24'd0, word_sh[7:0]};
      end
      2'b01: begin
        be      = lane_q[1] ? 4'b1100 : 4'b0011;
        wr_rep  = {2{wdata_q[15:0]}};
        rd_lane = {16'd0, (lane_q[1] ? word[31:16] : word[15:0])};
      end
      default: begin
        be      = 4'b1111;
        wr_rep  = wdata_q;
        rd_lane = word;
      end
    endcase
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wr_rep[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_RESP) && we_q && !err_q) begin
      mem[idx_q] <= merged;
    end
  end

  assign ready_w   = (state_q == S_RESP);
  assign bus.ready = ready_w;
  assign bus.err   = ready_w & err_q;
  assign bus.rdata = (ready_w && !err_q) ? rd_lane : 32'd0;
  // The response cycle never stalls, so the RESP term reduces to zero.
  assign bus.stall = ((state_q == S_IDLE) && bus.req) || (state_q == S_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +-----------------------------------------------------------------------+
// | tb_dmem_responder : scoreboard bench, WAIT=2 and WAIT=0 builds (rev 1.0)|
// +-----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rd;
    bit          err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(bit sel);
    return sel ? bus_b.ready : bus_a.ready;
  endfunction

  function automatic logic stl(bit sel);
    return sel ? bus_b.stall : bus_a.stall;
  endfunction

  task automatic drive(bit sel, bit req, bit we, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata);
    if (sel) begin
      bus_b.req = req; bus_b.we = we; bus_b.size = size; bus_b.addr = addr; bus_b.wdata = wdata;
    end else begin
      bus_a.req = req; bus_a.we = we; bus_a.size = size; bus_a.addr = addr; bus_a.wdata = wdata;
    end
  endtask

  // Called just after a rising edge with the target idle; returns one cycle after ready.
  task automatic issue(bit sel, bit we, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata,
                       logic [31:0] exp_rd, bit exp_err);
    exp_t e;
    int   lat;
    bit   got;
    drive(sel, 1'b1, we, size, addr, wdata);
    lat      = exp_err ? 1 : (sel ? 1 : 3);
    e.rdata  = exp_rd;
    e.chk_rd = !we || exp_err;
    e.err    = exp_err;
    e.cyc    = cyc + lat;
    if (sel) q_b.push_back(e); else q_a.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (rdy(sel)) begin
        got = 1'b1;
        check(sel ? "b_stall_in_ready" : "a_stall_in_ready", 32'(stl(sel)), 32'd0);
      end else begin
        check(sel ? "b_stall_pending" : "a_stall_pending", 32'(stl(sel)), 32'd1);
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got no ready for addr 0x%08h, expected ready within 40 cycles", addr);
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic mon_step(bit sel);
    exp_t        e;
    logic        r;
    logic        er;
    logic [31:0] rd;
    r  = sel ? bus_b.ready : bus_a.ready;
    er = sel ? bus_b.err   : bus_a.err;
    rd = sel ? bus_b.rdata : bus_a.rdata;
    if (r) begin
      if ((sel ? q_b.size() : q_a.size()) == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_unexpected_ready: got ready=1, expected ready=0 (cycle %0d)", sel ? "b" : "a", cyc);
      end else begin
        e = sel ? q_b.pop_front() : q_a.pop_front();
        check(sel ? "b_err" : "a_err", 32'(er), 32'(e.err));
        if (e.chk_rd) check(sel ? "b_rdata" : "a_rdata", rd, e.rdata);
        check(sel ? "b_ready_cycle" : "a_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check(sel ? "b_idle_rdata" : "a_idle_rdata", rd, 32'd0);
      check(sel ? "b_idle_err" : "a_idle_err", 32'(er), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(1'b0);
      mon_step(1'b1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", 32'(bus_a.ready), 32'd0);
    check("rst_a_err",   32'(bus_a.err),   32'd0);
    check("rst_a_rdata", bus_a.rdata,      32'd0);
    check("rst_a_stall", 32'(bus_a.stall), 32'd0);
    check("rst_b_ready", 32'(bus_b.ready), 32'd0);
    check("rst_b_rdata", bus_b.rdata,      32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // WAIT_CYCLES = 2 build
    issue(0, 1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0);
    issue(0, 0, 2'b10, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
    issue(0, 1, 2'b10, 32'h0000_0020, 32'h1122_3344, 32'h0, 0);
    issue(0, 1, 2'b00, 32'h0000_0022, 32'h1234_56AA, 32'h0, 0);
    issue(0, 0, 2'b10, 32'h0000_0020, 32'h0,         32'h11AA_3344, 0);
    issue(0, 0, 2'b01, 32'h0000_0022, 32'h0,         32'h0000_11AA, 0);
    issue(0, 0, 2'b00, 32'h0000_0023, 32'h0,         32'h0000_0011, 0);
    issue(0, 0, 2'b00, 32'h0000_0021, 32'h0,         32'h0000_0033, 0);
    issue(0, 1, 2'b01, 32'h0000_0020, 32'hABCD_5566, 32'h0, 0);
    issue(0, 0, 2'b10, 32'h0000_0020, 32'h0,         32'h11AA_5566, 0);
    issue(0, 1, 2'b10, 32'h0000_0024, 32'hCAFE_F00D, 32'h0, 0);
    issue(0, 0, 2'b01, 32'h0000_0021, 32'h0,         32'h0, 1);
    issue(0, 1, 2'b10, 32'h0000_0026, 32'h0000_0000, 32'h0, 1);
    issue(0, 1, 2'b01, 32'h0000_0025, 32'h0000_1111, 32'h0, 1);
    issue(0, 0, 2'b10, 32'h0000_0022, 32'h0,         32'h0, 1);
    issue(0, 0, 2'b11, 32'h0000_0024, 32'h0,         32'h0, 1);
    issue(0, 0, 2'b10, 32'h0000_0024, 32'h0,         32'hCAFE_F00D, 0);
    issue(0, 1, 2'b10, 32'h0000_1000, 32'h5555_5555, 32'h0, 1);
    issue(0, 0, 2'b10, 32'h8000_0000, 32'h0,         32'h0, 1);
    issue(0, 1, 2'b10, 32'h0000_0FFC, 32'h0BAD_C0DE, 32'h0, 0);
    issue(0, 1, 2'b00, 32'h0000_0FFF, 32'h0000_0077, 32'h0, 0);
    issue(0, 0, 2'b10, 32'h0000_0FFC, 32'h0,         32'h77AD_C0DE, 0);

    // Reset during WAIT of a store must leave memory untouched
    issue(0, 1, 2'b10, 32'h0000_0030, 32'h55AA_1234, 32'h0, 0);
    drive(0, 1'b1, 1'b1, 2'b10, 32'h0000_0030, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rst_a = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus_a.ready), 32'd0);
    check("abort_err",   32'(bus_a.err),   32'd0);
    check("abort_rdata", bus_a.rdata,      32'd0);
    check("abort_stall", 32'(bus_a.stall), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    issue(0, 0, 2'b10, 32'h0000_0030, 32'h0,         32'h55AA_1234, 0);

    // WAIT_CYCLES = 0 build, back-to-back
    issue(1, 1, 2'b10, 32'h0000_0040, 32'h0102_0304, 32'h0, 0);
    issue(1, 1, 2'b10, 32'h0000_0044, 32'hA5A5_A5A5, 32'h0, 0);
    issue(1, 0, 2'b10, 32'h0000_0040, 32'h0,         32'h0102_0304, 0);
    issue(1, 0, 2'b10, 32'h0000_0044, 32'h0,         32'hA5A5_A5A5, 0);
    issue(1, 0, 2'b00, 32'h0000_0042, 32'h0,         32'h0000_0002, 0);
    issue(1, 0, 2'b11, 32'h0000_0040, 32'h0,         32'h0, 1);
    issue(1, 0, 2'b01, 32'h0000_0046, 32'h0,         32'h0000_A5A5, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
